adder_pipe: RTL and testbench

- Parametrised, pipelined two's-complement adder/subtractor for the ALU datapath.
- Operand width is split into STAGES equal chunks. Each chunk uses one combinational chunk adder, and the carry is registered between stages.
- Valid/ready handshake on both sides, with backpressure and bubble collapse. Provides carry, signed-overflow and zero flags.
- Replaces fixed-width ripple adders where WIDTH × ripple delay exceeds the clock period.

---
 rtl/alu_pkg.sv | 18 +
 rtl/adder_chunk.sv | 17 +
 rtl/adder_pipe.sv | 153 +++++++++++++++
 tb/tb_adder_pipe.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encoding and signed-overflow helper.
// Imported by the adder pipeline and its chunk adder.
package alu_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Signed overflow from operand MSBs (B already inverted for SUB)
  // and the result MSB.
  function automatic logic sovf(
    input logic a,
    input logic b,
    input logic s
  );
    return (a == b) && (s != a);
  endfunction

endpackage

// File: rtl/adder_chunk.sv
// Combinational W-bit chunk adder with carry in/out.
// Ports: num_1, num_2 (W), c in; sum (W), carry out.
module adder_chunk #(
  parameter int W = 8
) (
  input  logic [W-1:0] num_1,
  input  logic [W-1:0] num_2,
  input  logic         c,
  output logic [W-1:0] sum,
  output logic         carry
);

  assign {carry, sum} = {1'b0, num_1}
                      + {1'b0, num_2}
                      + {{W{1'b0}}, c};

endmodule

// File: rtl/adder_pipe.sv
// Pipelined add/sub: one CHUNK-bit adder per stage, carry registered
// between stages, valid/ready on both sides with bubble collapse.
// Ports: clk, rst (sync, high); in_valid/in_ready, op, num_1, num_2, c;
//        out_valid/out_ready, sum, carry, overflow, zero.
module adder_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op,
  input  logic [WIDTH-1:0] num_1,
  input  logic [WIDTH-1:0] num_2,
  input  logic             c,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow,
  output logic             zero
);

  localparam int CHUNK = WIDTH / STAGES;
  localparam int L     = STAGES - 1;
  localparam int MSB   = WIDTH - 1;

  if (STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_bad_cfg
    $error("adder_pipe: bad WIDTH/STAGES");
  end

  // Stage registers; index s holds pipeline stage s+1.
  logic [STAGES-1:0] v_q;
  logic [WIDTH-1:0]  a_q [STAGES];
  logic [WIDTH-1:0]  b_q [STAGES];
  logic [WIDTH-1:0]  s_q [STAGES];
  logic              c_q [STAGES];
  logic              ovf_q;
  logic              zero_q;

  // Stage inputs (ports for stage 1, previous register otherwise).
  logic [WIDTH-1:0]  a_i [STAGES];
  logic [WIDTH-1:0]  b_i [STAGES];
  logic [WIDTH-1:0]  s_i [STAGES];
  logic              c_i [STAGES];
  logic [STAGES-1:0] v_i;

  logic [CHUNK-1:0]  ch_s [STAGES];
  logic              ch_c [STAGES];
  logic [WIDTH-1:0]  s_n  [STAGES];
  logic [STAGES-1:0] adv;

  logic [WIDTH-1:0]  b_eff;
  logic              c_eff;

  // A stage may advance if it or any later stage is empty, or the
  // consumer pops: closed form of the ripple adv chain.
  always_comb begin
    adv = '0;
    for (int s = 0; s < STAGES; s++) begin
      adv[s] = out_ready || (((~v_q) >> s) != '0);
    end
  end

  assign in_ready = adv[0] && !rst;

  always_comb begin
    b_eff = num_2;
    c_eff = c;
    case (op)
      OP_ADD: begin
        b_eff = num_2;
        c_eff = c;
      end
      OP_SUB: begin
        b_eff = ~num_2;
        c_eff = ~c;
      end
      default: ;
    endcase
  end

  always_comb begin
    a_i[0] = num_1;
    b_i[0] = b_eff;
    c_i[0] = c_eff;
    s_i[0] = '0;
    v_i    = '0;
    v_i[0] = in_valid && in_ready;
    for (int s = 1; s < STAGES; s++) begin
      a_i[s] = a_q[s-1];
      b_i[s] = b_q[s-1];
      c_i[s] = c_q[s-1];
      s_i[s] = s_q[s-1];
      v_i[s] = v_q[s-1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_chunk
    adder_chunk #(.W(CHUNK)) u_chunk (
      .num_1 (a_i[k][k*CHUNK +: CHUNK]),
      .num_2 (b_i[k][k*CHUNK +: CHUNK]),
      .c     (c_i[k]),
      .sum   (ch_s[k]),
      .carry (ch_c[k])
    );
  end

  always_comb begin
    for (int s = 0; s < STAGES; s++) begin
      s_n[s] = s_i[s];
      s_n[s][s*CHUNK +: CHUNK] = ch_s[s];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q    <= '0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
      for (int s = 0; s < STAGES; s++) begin
        a_q[s] <= '0;
        b_q[s] <= '0;
        s_q[s] <= '0;
        c_q[s] <= 1'b0;
      end
    end else begin
      for (int s = 0; s < STAGES; s++) begin
        if (adv[s]) begin
          v_q[s] <= v_i[s];
          a_q[s] <= a_i[s];
          b_q[s] <= b_i[s];
          s_q[s] <= s_n[s];
          c_q[s] <= ch_c[s];
        end
      end
      if (adv[L]) begin
        ovf_q  <= sovf(a_i[L][MSB], b_i[L][MSB], s_n[L][MSB]);
        zero_q <= (s_n[L] == '0);
      end
    end
  end

  assign out_valid = v_q[L];
  assign sum       = s_q[L];
  assign carry     = c_q[L];
  assign overflow  = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_adder_pipe.sv
// Directed bench for adder_pipe: 32/4 pipeline plus a 16/1 instance.
// Inputs driven and outputs checked on the falling clock edge.
module tb_adder_pipe;

  logic clk;
  logic rst;

  logic        iv, ir, op, ci, ov, ordy, cy, of, zr;
  logic [31:0] a, b, s;

  logic        iv2, ir2, op2, ci2, ov2, ordy2, cy2, of2, zr2;
  logic [15:0] a2, b2, s2;

  int total;
  int bad;

  adder_pipe #(.WIDTH(32), .STAGES(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (iv),
    .in_ready  (ir),
    .op        (op),
    .num_1     (a),
    .num_2     (b),
    .c         (ci),
    .out_valid (ov),
    .out_ready (ordy),
    .sum       (s),
    .carry     (cy),
    .overflow  (of),
    .zero      (zr)
  );

  adder_pipe #(.WIDTH(16), .STAGES(1)) dut1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (iv2),
    .in_ready  (ir2),
    .op        (op2),
    .num_1     (a2),
    .num_2     (b2),
    .c         (ci2),
    .out_valid (ov2),
    .out_ready (ordy2),
    .sum       (s2),
    .carry     (cy2),
    .overflow  (of2),
    .zero      (zr2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic drv(input logic o, input logic [31:0] x,
                     input logic [31:0] y, input logic k);
    iv = 1'b1;
    op = o;
    a  = x;
    b  = y;
    ci = k;
  endtask

  task automatic flags(input string tag, input logic [31:0] es,
                       input logic ec, input logic eo, input logic ez);
    chk({tag, "_v"}, ov, 1);
    chk({tag, "_sum"}, s, es);
    chk({tag, "_cy"}, cy, ec);
    chk({tag, "_of"}, of, eo);
    chk({tag, "_z"}, zr, ez);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    iv = 0; op = 0; a = 0; b = 0; ci = 0; ordy = 1;
    iv2 = 0; op2 = 0; a2 = 0; b2 = 0; ci2 = 0; ordy2 = 1;

    // reset state
    step();
    step();
    chk("rst_ov", ov, 0);
    chk("rst_sum", s, 0);
    chk("rst_cy", cy, 0);
    chk("rst_of", of, 0);
    chk("rst_z", zr, 0);
    chk("rst_ir", ir, 0);
    chk("rst_ov1", ov2, 0);
    rst = 1'b0;
    step();
    chk("ir_after_rst", ir, 1);

    // ADD FFFFFFFF + 1: latency and wrap to zero
    drv(1'b0, 32'hFFFF_FFFF, 32'h1, 1'b0);
    step();
    iv = 1'b0;
    chk("lat_t0", ov, 0);
    step();
    chk("lat_t1", ov, 0);
    step();
    chk("lat_t2", ov, 0);
    step();
    flags("add_wrap", 32'h0, 1, 0, 1);

    // SUB pair back to back
    step();
    chk("gap_ov", ov, 0);
    drv(1'b1, 32'h8000_0000, 32'h1, 1'b0);
    step();
    drv(1'b1, 32'h5, 32'h7, 1'b0);
    step();
    iv = 1'b0;
    step();
    step();
    flags("sub_ovf", 32'h7FFF_FFFF, 1, 1, 0);
    step();
    flags("sub_neg", 32'hFFFF_FFFE, 0, 0, 0);
    step();
    chk("sub_drain", ov, 0);

    // 8 back-to-back ADDs, full throughput
    for (int j = 0; j < 12; j++) begin
      if (j > 0) step();
      if (j < 8) chk("b2b_ir", ir, 1);
      if (j >= 4) begin
        chk("b2b_v", ov, 1);
        chk("b2b_sum", s, 32'h100 + j - 4);
      end
      if (j < 8) drv(1'b0, j, 32'h100, 1'b0);
      else iv = 1'b0;
    end
    step();
    chk("b2b_end", ov, 0);

    // backpressure: fill, stall 3 cycles, push+pop on full pipe
    ordy = 1'b0;
    for (int j = 0; j < 4; j++) begin
      if (j > 0) step();
      chk("bp_fill_ir", ir, 1);
      drv(1'b0, 32'h200, j, 1'b0);
    end
    for (int j = 4; j < 7; j++) begin
      step();
      chk("bp_full_ir", ir, 0);
      chk("bp_hold_v", ov, 1);
      chk("bp_hold_sum", s, 32'h200);
      drv(1'b0, 32'h200, 32'h4, 1'b0);
    end
    ordy = 1'b1;
    #1;
    chk("bp_pushpop_ir", ir, 1);
    for (int j = 1; j < 5; j++) begin
      step();
      iv = 1'b0;
      chk("bp_drain_v", ov, 1);
      chk("bp_drain_sum", s, 32'h200 + j);
    end
    step();
    chk("bp_end", ov, 0);

    // reset with 3 in flight plus an offered accept
    for (int j = 0; j < 3; j++) begin
      if (j > 0) step();
      drv(1'b0, 32'h300, j, 1'b0);
    end
    step();
    rst = 1'b1;
    drv(1'b0, 32'h3FF, 32'h0, 1'b0);
    #1;
    chk("mrst_ir", ir, 0);
    step();
    chk("mrst_ov", ov, 0);
    chk("mrst_sum", s, 0);
    chk("mrst_cy", cy, 0);
    chk("mrst_of", of, 0);
    chk("mrst_z", zr, 0);
    rst = 1'b0;
    iv  = 1'b0;
    #1;
    chk("mrst_ir_after", ir, 1);
    for (int j = 0; j < 6; j++) begin
      step();
      chk("mrst_no_stale", ov, 0);
    end

    // STAGES = 1, WIDTH = 16
    chk("s1_idle", ov2, 0);
    iv2 = 1'b1; op2 = 1'b0; a2 = 16'h1234; b2 = 16'h0FFF; ci2 = 1'b1;
    step();
    chk("s1_v", ov2, 1);
    chk("s1_sum", s2, 16'h2234);
    chk("s1_cy", cy2, 0);
    chk("s1_z", zr2, 0);
    chk("s1_of", of2, 0);
    op2 = 1'b1; a2 = 16'h1234; b2 = 16'h1234; ci2 = 1'b0;
    step();
    iv2 = 1'b0;
    chk("s1_sub_v", ov2, 1);
    chk("s1_sub_sum", s2, 16'h0);
    chk("s1_sub_cy", cy2, 1);
    chk("s1_sub_z", zr2, 1);
    step();
    chk("s1_end", ov2, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
